// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier sequencer driving an external shared adder.
// Define ALU_MUL_EARLY_TERM_EN to exit RUN once the multiplier is exhausted.
module alu_mul_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  input  logic [XLEN-1:0] add_sum
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [CW-1:0]   r_count;
  logic            r_start_ready;
  logic            r_res_valid;
  logic            r_busy;
  logic            r_run;
  logic            w_last;

`ifdef ALU_MUL_EARLY_TERM_EN
  // No set bits left above bit 0: later steps would add nothing.
  assign w_last = (r_count == LAST) ||
                  ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_count == LAST);
`endif

  assign start_ready = r_start_ready;
  assign res_valid   = r_res_valid;
  assign busy        = r_busy;
  assign result      = r_res_valid ? r_acc : '0;
  assign add_a       = r_run ? r_acc : '0;
  assign add_b       = r_run ? r_mcand : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_count       <= '0;
      r_start_ready <= 1'b1;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_run         <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_state       <= S_RUN;
            r_acc         <= '0;
            r_mcand       <= op_a;
            r_mplier      <= op_b;
            r_count       <= '0;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_run         <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= add_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_last) begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
            r_run       <= 1'b0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state       <= S_IDLE;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer; models the shared adder.
// Expected latency follows ALU_MUL_EARLY_TERM_EN when defined.
module tb_alu_mul_sequencer;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_valid;
  logic            start_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] result;
  logic            busy;
  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic [XLEN-1:0] add_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign add_sum = add_a + add_b;

  alu_mul_sequencer #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .busy       (busy),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum)
  );

  typedef struct {
    string       nm;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [63:0] b);
    int n;
`ifdef ALU_MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
`else
    n = 64;
`endif
    return n;
  endfunction

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp,
                        input int hold, input bit rr_early);
    int lat;
    res_ready   = rr_early;
    op_a        = a;
    op_b        = b;
    start_valid = 1'b1;
    chk({nm, " start_ready"}, 64'(start_ready), 64'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk({nm, " busy"}, 64'(busy), 64'd1);
    chk({nm, " add_a0"}, add_a, 64'd0);
    chk({nm, " add_b0"}, add_b, a);
    wait_res(lat);
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat(b)));
    chk({nm, " res_valid"}, 64'(res_valid), 64'd1);
    chk({nm, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " hold result"}, result, exp);
      chk({nm, " hold valid"}, 64'(res_valid), 64'd1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({nm, " idle ready"}, 64'(start_ready), 64'd1);
    chk({nm, " idle busy"}, 64'(busy), 64'd0);
    chk({nm, " idle valid"}, 64'(res_valid), 64'd0);
    chk({nm, " idle result"}, result, 64'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    vecs[0] = '{"3x5", 64'd3, 64'd5, 64'd15};
    vecs[1] = '{"wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{"b0", 64'h1234_5678, 64'd0, 64'd0};
    vecs[3] = '{"a0", 64'd0, 64'hFFFF, 64'd0};
    vecs[4] = '{"neg", 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
                64'hFFFF_FFFF_FFFF_FFEB};
    vecs[5] = '{"deadbeef", 64'hDEAD_BEEF, 64'h1_0001,
                64'hDEAE_9D9C_BEEF};
    vecs[6] = '{"msb", 64'd1, 64'h8000_0000_0000_0000,
                64'h8000_0000_0000_0000};
    vecs[7] = '{"7x9", 64'd7, 64'd9, 64'd63};
    vecs[8] = '{"one", 64'h0123_4567_89AB_CDEF, 64'd1,
                64'h0123_4567_89AB_CDEF};

    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst start_ready", 64'(start_ready), 64'd1);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst res_valid", 64'(res_valid), 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst add_a", add_a, 64'd0);
    chk("rst add_b", add_b, 64'd0);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].exp,
             0, (i % 2) == 0);

    run_op("stall", 64'h1234, 64'h10, 64'h12340, 10, 1'b0);

    // Operands offered while busy must be ignored.
    op_a = 64'd6; op_b = 64'd7;
    start_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    op_a = 64'd100; op_b = 64'd100;
    repeat (2) @(posedge clk);
    #1 chk("ign ready run", 64'(start_ready), 64'd0);
    wait_res(lat);
    chk("ign result", result, 64'd42);
    repeat (3) @(posedge clk);
    #1 chk("ign hold", result, 64'd42);
    chk("ign ready done", 64'(start_ready), 64'd0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("ign idle ready", 64'(start_ready), 64'd1);
    chk("ign idle busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("ign 2nd busy", 64'(busy), 64'd1);
    chk("ign 2nd add_b", add_b, 64'd100);
    wait_res(lat);
    chk("ign 2nd result", result, 64'd10000);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Abort mid-RUN at count==20.
    op_a = 64'd5; op_b = 64'h8000_0000_0000_0001;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort start_ready", 64'(start_ready), 64'd1);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort res_valid", 64'(res_valid), 64'd0);
    chk("abort add_a", add_a, 64'd0);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (res_valid || busy) seen = 1'b1;
    end
    chk("abort no result", 64'(seen), 64'd0);
    run_op("post abort", 64'd7, 64'd9, 64'd63, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
